// File: rtl/adder_response_monitor.sv
// -----------------------------------------------------------------------------
// adder_response_monitor
//
// Purpose
//   Consumer of a ripple-carry adder under test. For each accepted vector it
//   captures the applied operands {a,b,cin} together with the adder response
//   {cout,s}. It checks that response against a golden a+b+cin, counts the
//   failing vectors (saturating) and records the 0-based index of the first
//   failing vector of the session. A session accepts exactly NVEC vectors.
//
// Optional feature
//   ADDER_MON_MISR_EN : when defined, adds a 16-bit MISR over the responses
//                       and the `signature` output port.
//
// Parameters
//   WIDTH  operand width (response is WIDTH+1 bits {cout,s}; WIDTH <= 15)
//   NVEC   vectors accepted per session (1 .. 2**CNT_W-1)
//   CNT_W  width of vector index, mismatch counter and first_fail_idx
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   begin a session (honoured in IDLE or DONE only)
//   in_valid       in   a/b/cin/s/cout hold a valid vector
//   in_ready       out  monitor accepts; transfer = in_valid & in_ready
//   a, b           in   operands applied to the adder
//   cin            in   carry-in applied to the adder
//   s              in   adder sum response
//   cout           in   adder carry-out response
//   busy           out  session running (RUN)
//   done           out  session finished (DONE), held until next start
//   mismatch_cnt   out  failing vectors this session, saturating
//   first_fail_vld out  at least one failing vector this session
//   first_fail_idx out  index of the first failing vector
//   signature      out  MISR signature (ADDER_MON_MISR_EN only)
// -----------------------------------------------------------------------------
module adder_response_monitor #(
    parameter int WIDTH = 4,
    parameter int NVEC  = 256,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_fail_vld,
    output logic [CNT_W-1:0] first_fail_idx
`ifdef ADDER_MON_MISR_EN
    ,
    output logic [15:0]      signature
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NVEC - 1);

    // Reference result of the adder, carry kept as the top bit.
    function automatic logic [WIDTH:0] golden_sum(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             c
    );
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

`ifdef ADDER_MON_MISR_EN
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // One MISR step: CCITT-style shift with the response folded into the LSBs.
    function automatic logic [15:0] misr_step(
        input logic [15:0]  sig,
        input logic [WIDTH:0] resp
    );
        return {sig[14:0], 1'b0}
             ^ (sig[15] ? 16'h1021 : 16'h0000)
             ^ {{(15-WIDTH){1'b0}}, resp};
    endfunction
`endif

    // Control state and registered outputs
    state_e             state_q, state_d;
    logic               in_ready_q;
    logic               busy_q;
    logic               done_q;

    // Session counters
    logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]   mismatch_cnt_q, mismatch_cnt_d;
    logic               ff_vld_q, ff_vld_d;
    logic [CNT_W-1:0]   ff_idx_q, ff_idx_d;

    // Stage 1: captured vector awaiting its check
    logic               s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0]   s1_a_q;
    logic [WIDTH-1:0]   s1_b_q;
    logic               s1_cin_q;
    logic [WIDTH:0]     s1_resp_q;
    logic [CNT_W-1:0]   s1_idx_q;

    // Combinational helpers
    logic               xfer_s;
    logic               start_run_s;
    logic               fail_s;

`ifdef ADDER_MON_MISR_EN
    logic [15:0]        sig_q, sig_d;
`endif

    // in_ready_q mirrors "state is RUN", so it alone qualifies a transfer.
    assign xfer_s      = in_valid & in_ready_q;
    assign start_run_s = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign fail_s      = s1_vld_q &
                         (golden_sum(s1_a_q, s1_b_q, s1_cin_q) != s1_resp_q);

    // Next-state decode for the session FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Last vector leaves RUN on its own transfer edge.
                if (xfer_s && (vec_cnt_q == LAST_IDX)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Wait one edge for the last captured vector to be folded.
                if (!s1_vld_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of vector index, stage-1 valid and result accumulators.
    always_comb begin
        vec_cnt_d      = vec_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        ff_vld_d       = ff_vld_q;
        ff_idx_d       = ff_idx_q;
        s1_vld_d       = xfer_s;
        if (start_run_s) begin
            vec_cnt_d      = CNT_ZERO;
            mismatch_cnt_d = CNT_ZERO;
            ff_vld_d       = 1'b0;
            ff_idx_d       = CNT_ZERO;
        end else begin
            if (xfer_s) begin
                vec_cnt_d = vec_cnt_q + CNT_ONE;
            end else begin
                vec_cnt_d = vec_cnt_q;
            end
            if (fail_s && (mismatch_cnt_q != CNT_MAX)) begin
                mismatch_cnt_d = mismatch_cnt_q + CNT_ONE;
            end else begin
                mismatch_cnt_d = mismatch_cnt_q;
            end
            // Only the first failure of the session is recorded.
            if (fail_s && !ff_vld_q) begin
                ff_vld_d = 1'b1;
                ff_idx_d = s1_idx_q;
            end else begin
                ff_vld_d = ff_vld_q;
                ff_idx_d = ff_idx_q;
            end
        end
    end

`ifdef ADDER_MON_MISR_EN
    // Next MISR value: seeded at session start, advanced per checked response.
    always_comb begin
        sig_d = sig_q;
        if (start_run_s) begin
            sig_d = MISR_SEED;
        end else if (s1_vld_q) begin
            sig_d = misr_step(sig_q, s1_resp_q);
        end else begin
            sig_d = sig_q;
        end
    end
`endif

    // FSM state plus status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == ST_RUN);
            busy_q     <= (state_d == ST_RUN);
            done_q     <= (state_d == ST_DONE);
        end
    end

    // Session counters and first-failure record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt_q      <= CNT_ZERO;
            mismatch_cnt_q <= CNT_ZERO;
            ff_vld_q       <= 1'b0;
            ff_idx_q       <= CNT_ZERO;
        end else begin
            vec_cnt_q      <= vec_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            ff_vld_q       <= ff_vld_d;
            ff_idx_q       <= ff_idx_d;
        end
    end

    // Stage-1 capture of operands, response and vector index on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_a_q    <= {WIDTH{1'b0}};
            s1_b_q    <= {WIDTH{1'b0}};
            s1_cin_q  <= 1'b0;
            s1_resp_q <= {(WIDTH+1){1'b0}};
            s1_idx_q  <= CNT_ZERO;
        end else begin
            s1_vld_q <= s1_vld_d;
            if (xfer_s) begin
                s1_a_q    <= a;
                s1_b_q    <= b;
                s1_cin_q  <= cin;
                s1_resp_q <= {cout, s};
                s1_idx_q  <= vec_cnt_q;
            end else begin
                s1_a_q    <= s1_a_q;
                s1_b_q    <= s1_b_q;
                s1_cin_q  <= s1_cin_q;
                s1_resp_q <= s1_resp_q;
                s1_idx_q  <= s1_idx_q;
            end
        end
    end

`ifdef ADDER_MON_MISR_EN
    // MISR register; reset value equals the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;
`endif

    assign in_ready       = in_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign first_fail_vld = ff_vld_q;
    assign first_fail_idx = ff_idx_q;

endmodule

// File: tb/tb_adder_response_monitor.sv
// -----------------------------------------------------------------------------
// tb_adder_response_monitor
//
// Bench for adder_response_monitor. Main instance: WIDTH=4, NVEC=4, CNT_W=16,
// checked every cycle against a transaction-level model (pending-result queue,
// accepted-vector count, plain integer arithmetic). Second instance: NVEC=3,
// CNT_W=2, used for saturation and mid-session reset with literal checks.
// Define ADDER_MON_MISR_EN to include the signature checks.
// -----------------------------------------------------------------------------
module tb_adder_response_monitor;

    localparam int W    = 4;
    localparam int NV   = 4;
    localparam int CW   = 16;
    localparam int NV2  = 3;
    localparam int CW2  = 2;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          rst2_n   = 1'b1;
    logic          start    = 1'b0;
    logic          start2   = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  a        = '0;
    logic [W-1:0]  b        = '0;
    logic          cin      = 1'b0;
    logic [W-1:0]  s        = '0;
    logic          cout     = 1'b0;

    logic          in_ready, busy, done, ffv;
    logic [CW-1:0] mcnt, ffi;
    logic          in_ready2, busy2, done2, ffv2;
    logic [CW2-1:0] mcnt2, ffi2;
`ifdef ADDER_MON_MISR_EN
    logic [15:0]   signature, signature2;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    adder_response_monitor #(.WIDTH(W), .NVEC(NV), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .busy(busy), .done(done), .mismatch_cnt(mcnt),
        .first_fail_vld(ffv), .first_fail_idx(ffi)
`ifdef ADDER_MON_MISR_EN
        , .signature(signature)
`endif
    );

    adder_response_monitor #(.WIDTH(W), .NVEC(NV2), .CNT_W(CW2)) dut_sat (
        .clk(clk), .rst_n(rst2_n), .start(start2), .in_valid(in_valid),
        .in_ready(in_ready2), .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .busy(busy2), .done(done2), .mismatch_cnt(mcnt2),
        .first_fail_vld(ffv2), .first_fail_idx(ffi2)
`ifdef ADDER_MON_MISR_EN
        , .signature(signature2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] misr_ref(input logic [15:0] sg, input int resp);
        logic [15:0] nx;
        nx = {sg[14:0], 1'b0};
        if (sg[15]) nx = nx ^ 16'h1021;
        nx = nx ^ 16'(resp);
        return nx;
    endfunction

    // ---------------- behavioural model (main instance) ----------------
    bit          m_run, m_drain, m_done, m_ffv;
    int          m_acc, m_cnt, m_ffi;
    logic [15:0] m_sig;
    int          pend_fail[$];
    int          pend_idx[$];
    int          pend_resp[$];

    initial begin : model
        bit had;
        int f, ix, rs, gold;
        m_run = 0; m_drain = 0; m_done = 0; m_ffv = 0;
        m_acc = 0; m_cnt = 0; m_ffi = 0; m_sig = 16'hFFFF;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run = 0; m_drain = 0; m_done = 0; m_ffv = 0;
                m_acc = 0; m_cnt = 0; m_ffi = 0; m_sig = 16'hFFFF;
                pend_fail.delete(); pend_idx.delete(); pend_resp.delete();
            end else begin
                had = (pend_fail.size() > 0);
                if (had) begin
                    f  = pend_fail.pop_front();
                    ix = pend_idx.pop_front();
                    rs = pend_resp.pop_front();
                    if (f != 0) begin
                        if (m_cnt < 65535) m_cnt++;
                        if (!m_ffv) begin
                            m_ffv = 1;
                            m_ffi = ix;
                        end
                    end
                    m_sig = misr_ref(m_sig, rs);
                end
                if (!m_run && !m_drain && start) begin
                    m_run = 1; m_done = 0; m_acc = 0; m_cnt = 0;
                    m_ffv = 0; m_ffi = 0; m_sig = 16'hFFFF;
                end else if (m_run && in_valid) begin
                    gold = int'(a) + int'(b) + int'(cin);
                    rs   = int'(cout) * 16 + int'(s);
                    pend_fail.push_back((gold != rs) ? 1 : 0);
                    pend_idx.push_back(m_acc);
                    pend_resp.push_back(rs);
                    m_acc++;
                    if (m_acc == NV) begin
                        m_run   = 0;
                        m_drain = 1;
                    end
                end else if (m_drain && !had) begin
                    m_drain = 0;
                    m_done  = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            chk("cyc_in_ready", 32'(in_ready), 32'(m_run));
            chk("cyc_busy",     32'(busy),     32'(m_run));
            chk("cyc_done",     32'(done),     32'(m_done));
            chk("cyc_mcnt",     32'(mcnt),     32'(m_cnt));
            chk("cyc_ffv",      32'(ffv),      32'(m_ffv));
            chk("cyc_ffi",      32'(ffi),      32'(m_ffi));
`ifdef ADDER_MON_MISR_EN
            chk("cyc_sig",      32'(signature), 32'(m_sig));
`endif
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic vec(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                       input logic [3:0] vs, input logic vco);
        in_valid = 1'b1;
        a = va; b = vb; cin = vc; s = vs; cout = vco;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60 && !done; i++) tick();
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic rand_session(input int gap_pct, input int err_pct);
        int n, cyc, g;
        n = 0; cyc = 0;
        pulse_start();
        while (n < NV && cyc < 200) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            a   = 4'($urandom_range(15));
            b   = 4'($urandom_range(15));
            cin = 1'($urandom_range(1));
            g   = int'(a) + int'(b) + int'(cin);
            if ($urandom_range(99) < err_pct) begin
                s    = 4'($urandom_range(15));
                cout = 1'($urandom_range(1));
            end else begin
                s    = 4'(g);
                cout = 1'(g >> 4);
            end
            if (in_valid && in_ready) n++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        wait_done("rand_done");
    endtask

    // ---------------- test sequence ----------------
    initial begin : stim
        int n;
        #1;
        rst_n = 1'b0; rst2_n = 1'b0;
        in_valid = 1'b1;
        start = 1'b0;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_mcnt",     32'(mcnt),     32'd0);
        chk("rst_ffv",      32'(ffv),      32'd0);
        chk("rst_ffi",      32'(ffi),      32'd0);
`ifdef ADDER_MON_MISR_EN
        chk("rst_sig",      32'(signature), 32'hFFFF);
`endif
        in_valid = 1'b0;
        rst_n = 1'b1; rst2_n = 1'b1;
        tick();
        // in_valid while IDLE has no effect
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("idle_ignore_busy", 32'(busy), 32'd0);

        // Clean session
        pulse_start();
        chk("clean_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) vec(4'd3, 4'd5, 1'b1, 4'd9, 1'b0);
        chk("clean_ready_drain", 32'(in_ready), 32'd0);
        tick();
        chk("clean_done_k1", 32'(done), 32'd0);
        tick();
        chk("clean_done_k2", 32'(done), 32'd1);
        chk("clean_mcnt", 32'(mcnt), 32'd0);
        chk("clean_ffv",  32'(ffv),  32'd0);

        // Fault at vector 2
        pulse_start();
        vec(4'd3, 4'd5, 1'b1, 4'd9, 1'b0);
        vec(4'd3, 4'd5, 1'b1, 4'd9, 1'b0);
        vec(4'd3, 4'd5, 1'b1, 4'd8, 1'b0);
        vec(4'd3, 4'd5, 1'b1, 4'd9, 1'b0);
        tick(); tick();
        chk("f1_done", 32'(done), 32'd1);
        chk("f1_mcnt", 32'(mcnt), 32'd1);
        chk("f1_ffv",  32'(ffv),  32'd1);
        chk("f1_ffi",  32'(ffi),  32'd2);

        // Faults at vectors 2 and 3
        pulse_start();
        vec(4'd3, 4'd5, 1'b1, 4'd9, 1'b0);
        vec(4'd3, 4'd5, 1'b1, 4'd9, 1'b0);
        vec(4'd3, 4'd5, 1'b1, 4'd8, 1'b0);
        vec(4'd3, 4'd5, 1'b1, 4'd8, 1'b0);
        tick(); tick();
        chk("f2_mcnt", 32'(mcnt), 32'd2);
        chk("f2_ffi",  32'(ffi),  32'd2);

        // Start from DONE clears results
        pulse_start();
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_mcnt", 32'(mcnt), 32'd0);
        chk("restart_ffv",  32'(ffv),  32'd0);
        chk("restart_done", 32'(done), 32'd0);

        // in_valid toggling, max operands
        n = 0;
        a = 4'd15; b = 4'd15; cin = 1'b1; s = 4'd15; cout = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            if (in_valid && in_ready) n++;
            tick();
        end
        in_valid = 1'b0;
        chk("toggle_xfers", 32'(n), 32'd4);
        tick();
        chk("toggle_done", 32'(done), 32'd1);
        chk("toggle_mcnt", 32'(mcnt), 32'd0);

        // Reset mid-session on the main instance
        pulse_start();
        vec(4'd1, 4'd1, 1'b0, 4'd7, 1'b0);
        vec(4'd1, 4'd1, 1'b0, 4'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mcnt", 32'(mcnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_done", 32'(done), 32'd0);

`ifdef ADDER_MON_MISR_EN
        pulse_start();
        vec(4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        chk("misr_one_vec", 32'(signature), 32'hEFDF);
        for (int i = 0; i < 3; i++) vec(4'd2, 4'd2, 1'b0, 4'd4, 1'b0);
        wait_done("misr_done");
`endif

        // Randomized sessions
        for (int k = 0; k < 24; k++) rand_session(k % 4 * 20, 40);

        // Second instance: all three vectors fail (main instance sits in DONE)
        start2 = 1'b1; tick(); start2 = 1'b0;
        chk("sat_busy", 32'(busy2), 32'd1);
        for (int i = 0; i < 3; i++) vec(4'd3, 4'd5, 1'b1, 4'd0, 1'b0);
        tick(); tick();
        chk("sat_done", 32'(done2), 32'd1);
        chk("sat_mcnt", 32'(mcnt2), 32'd3);
        chk("sat_ffv",  32'(ffv2),  32'd1);
        chk("sat_ffi",  32'(ffi2),  32'd0);

        // Second instance: reset mid-session
        start2 = 1'b1; tick(); start2 = 1'b0;
        vec(4'd3, 4'd5, 1'b1, 4'd0, 1'b0);
        tick();
        rst2_n = 1'b0;
        #1;
        chk("sat_rst_busy",  32'(busy2),     32'd0);
        chk("sat_rst_done",  32'(done2),     32'd0);
        chk("sat_rst_mcnt",  32'(mcnt2),     32'd0);
        chk("sat_rst_ffv",   32'(ffv2),      32'd0);
        chk("sat_rst_ready", 32'(in_ready2), 32'd0);
        tick();
        rst2_n = 1'b1;
        tick(); tick();
        chk("sat_rst_idle_done", 32'(done2), 32'd0);
        chk("sat_rst_idle_busy", 32'(busy2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
